// File: rtl/dmem_pkg.sv
// Shared types for the handshaked data memory.
//   - access size encodings, FSM states, response error codes
//   - request payload struct latched at accept
package dmem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 4;

    typedef logic [1:0] size_t;

    localparam size_t SZ_WORD = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_BYTE = 2'b10;
    localparam size_t SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_SIZE     = 2'b11
    } err_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        size_t             size;
        logic              is_unsigned;
    } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for sub-word accesses (purely combinational).
// Ports:
//   size, offset, is_unsigned : access shape
//   wdata     : right-aligned store data
//   rdata_raw : full RAM word at the target index
//   be        : byte enables, wdata_rep : store data replicated over lanes
//   rdata_ext : selected lane, sign/zero extended
//   err       : size/alignment error (range is checked by the caller)
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_t             size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata_raw,
    output logic [3:0]        be,
    output logic [XLEN-1:0]   wdata_rep,
    output logic [XLEN-1:0]   rdata_ext,
    output err_t              err
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    assign half_lane = offset[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    assign byte_lane = rdata_raw[{offset, 3'b000} +: 8];

    // Lane decode, replication, extension and alignment check
    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
        err       = ERR_OK;
        case (size)
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata_raw;
                if (offset != 2'b00) err = ERR_MISALIGN;
            end
            SZ_HALF: begin
                be        = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
                if (offset[0]) err = ERR_MISALIGN;
            end
            SZ_BYTE: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            end
            default: begin
                err = ERR_SIZE;
            end
        endcase
    end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked data memory: one request at a time, WAIT_STATES extra cycles,
// registered response with extended load data or store acknowledge.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   req_valid/req_ready + req_* fields : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err : response channel
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              commit;

    req_t              req_in, req_q, req_cur;
    logic              in_range;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   raw_word;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   rdata_ext;
    err_t              align_err, err;
    logic              wr_en;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata,
                      size: req_size, is_unsigned: req_unsigned};

    // With zero wait states the commit happens on the accept edge itself,
    // so the live request is used until it has been latched.
    assign req_cur  = (state == ST_IDLE) ? req_in : req_q;
    assign in_range = req_cur.addr[31:2] < 30'(DEPTH_WORDS);
    assign idx      = req_cur.addr[AW+1:2];
    assign raw_word = mem[idx];

    dmem_lane_align u_align (
        .size        (req_cur.size),
        .offset      (req_cur.addr[1:0]),
        .is_unsigned (req_cur.is_unsigned),
        .wdata       (req_cur.wdata),
        .rdata_raw   (raw_word),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext),
        .err         (align_err)
    );

    // Priority: illegal size, then range, then alignment
    always_comb begin
        err = align_err;
        if (align_err != ERR_SIZE && !in_range) err = ERR_RANGE;
    end

    assign wr_en = commit && req_cur.we && (err == ERR_OK);

    // Next state, wait counter and commit strobe
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        commit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WAIT_INIT;
                    end else begin
                        state_nxt = ST_RESP;
                        commit    = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_RESP;
                    commit    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags, request latch and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            rsp_valid <= (state_nxt == ST_RESP);
            if (state == ST_IDLE && req_valid) req_q <= req_in;
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (!req_cur.we && err == ERR_OK) ? rdata_ext : '0;
            end
        end
    end

    // RAM is never cleared; reset only blocks writes while asserted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_hs.sv
// Directed bench for dmem_hs: instance 0 has no wait states, instance 1 has
// three. Both share the request fields, clock and reset; each has its own
// valid/ready pair and response outputs.
module tb_dmem_hs;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_rdata;
    logic [1:0][1:0]   rsp_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_hs #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid[0]),
        .req_ready    (req_ready[0]),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid[0]),
        .rsp_ready    (rsp_ready[0]),
        .rsp_rdata    (rsp_rdata[0]),
        .rsp_err      (rsp_err[0])
    );

    dmem_hs #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid[1]),
        .req_ready    (req_ready[1]),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid[1]),
        .rsp_ready    (rsp_ready[1]),
        .rsp_rdata    (rsp_rdata[1]),
        .rsp_err      (rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request and hold it through the accept edge; returns 1 time
    // unit after that edge with req_valid dropped.
    task automatic start_req(input int s, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] sz, input logic u);
        int guard;
        guard        = 0;
        req_we       = we;
        req_addr     = a;
        req_wdata    = d;
        req_size     = sz;
        req_unsigned = u;
        req_valid[s] = 1'b1;
        while (req_ready[s] !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", 32'(req_ready[s]), 32'd1);
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
    endtask

    // Cycles from the accept cycle to the first cycle with rsp_valid high
    task automatic wait_rsp(input int s, output int lat);
        lat = 1;
        while (rsp_valid[s] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic xact(input string tag, input int s, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic u,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        int lat;
        rsp_ready[s] = 1'b1;
        start_req(s, we, a, d, sz, u);
        wait_rsp(s, lat);
        check({tag, "_lat"},   32'(lat), (s == 0) ? 32'd1 : 32'd4);
        check({tag, "_rdata"}, rsp_rdata[s], exp_rdata);
        check({tag, "_err"},   32'(rsp_err[s]), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_n      = 1'b0;
        req_valid    = 2'b00;
        rsp_ready    = 2'b11;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(req_ready[s]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata[s], 32'd0);
            check("rst_rsp_err",   32'(rsp_err[s]), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ---- zero wait states ----
        xact("st_w_10",   0, 1'b1, 32'h10,  32'hDEADBEEF, 2'b00, 1'b0, 32'h0,        2'b00);
        xact("ld_w_10",   0, 1'b0, 32'h10,  32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 2'b00);
        xact("st_w0_10",  0, 1'b1, 32'h10,  32'h0,        2'b00, 1'b0, 32'h0,        2'b00);
        xact("st_b_13",   0, 1'b1, 32'h13,  32'h00000080, 2'b10, 1'b0, 32'h0,        2'b00);
        xact("ld_bs_13",  0, 1'b0, 32'h13,  32'h0,        2'b10, 1'b0, 32'hFFFFFF80, 2'b00);
        xact("ld_bu_13",  0, 1'b0, 32'h13,  32'h0,        2'b10, 1'b1, 32'h00000080, 2'b00);
        xact("ld_w_10b",  0, 1'b0, 32'h10,  32'h0,        2'b00, 1'b0, 32'h80000000, 2'b00);
        xact("ld_hs_12",  0, 1'b0, 32'h12,  32'h0,        2'b01, 1'b0, 32'hFFFF8000, 2'b00);
        xact("ld_hu_12",  0, 1'b0, 32'h12,  32'h0,        2'b01, 1'b1, 32'h00008000, 2'b00);
        xact("ld_h_11",   0, 1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h0,        2'b01);
        xact("st_w_12",   0, 1'b1, 32'h12,  32'h11111111, 2'b00, 1'b0, 32'h0,        2'b01);
        xact("ld_w_10c",  0, 1'b0, 32'h10,  32'h0,        2'b00, 1'b0, 32'h80000000, 2'b00);
        xact("ill_11",    0, 1'b0, 32'h11,  32'h0,        2'b11, 1'b0, 32'h0,        2'b11);
        xact("ld_w_400",  0, 1'b0, 32'h400, 32'h0,        2'b00, 1'b0, 32'h0,        2'b10);
        xact("ld_w_401",  0, 1'b0, 32'h401, 32'h0,        2'b00, 1'b0, 32'h0,        2'b10);
        xact("st_w_3fc",  0, 1'b1, 32'h3FC, 32'hCAFEF00D, 2'b00, 1'b0, 32'h0,        2'b00);
        xact("ld_w_3fc",  0, 1'b0, 32'h3FC, 32'h0,        2'b00, 1'b0, 32'hCAFEF00D, 2'b00);

        // ---- three wait states ----
        xact("w3_st_20",  1, 1'b1, 32'h20,  32'h0,        2'b00, 1'b0, 32'h0,        2'b00);
        xact("w3_st_24",  1, 1'b1, 32'h24,  32'hA5A5A5A5, 2'b00, 1'b0, 32'h0,        2'b00);

        // Load under backpressure: response held for five cycles
        rsp_ready[1] = 1'b0;
        start_req(1, 1'b0, 32'h24, 32'h0, 2'b00, 1'b0);
        check("bp_ready_wait", 32'(req_ready[1]), 32'd0);
        wait_rsp(1, lat);
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid[1]), 32'd1);
            check("bp_rdata", rsp_rdata[1], 32'hA5A5A5A5);
            check("bp_err",   32'(rsp_err[1]), 32'd0);
            check("bp_ready", 32'(req_ready[1]), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_done_valid", 32'(rsp_valid[1]), 32'd0);
        check("bp_done_ready", 32'(req_ready[1]), 32'd1);

        // Reset during WAIT of a store: transaction discarded, no write
        start_req(1, 1'b1, 32'h20, 32'h12345678, 2'b00, 1'b0);
        check("rm_ready_wait", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rm_req_ready", 32'(req_ready[1]), 32'd1);
        check("rm_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rm_rsp_rdata", rsp_rdata[1], 32'd0);
        check("rm_rsp_err",   32'(rsp_err[1]), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        xact("w3_ld_20",  1, 1'b0, 32'h20,  32'h0,        2'b00, 1'b0, 32'h0,        2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_hs.md
# dmem_hs

Parametrised, handshaked successor to the single-cycle data memory. Accepts one load/store request at a time on a valid/ready request channel and inserts a configurable number of wait states. It returns sign- or zero-extended load data, or a store acknowledge, on a valid/ready response channel. Misaligned, out-of-range and illegal-size accesses are flagged rather than silently executed. It sits between the LSU and on-chip RAM in the multi-cycle/pipelined core.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, minimum 4.
- WAIT_STATES, 0: extra cycles between accept and response; range 0..15.
- clk  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- req_valid  in  1: request present.
- req_ready  out  1: block can accept a request.
- req_we  in  1: 1 = store, 0 = load.
- req_addr  in  32: byte address.
- req_wdata  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2: 00 = word, 01 = half, 10 = byte, 11 = illegal.
- req_unsigned  in  1: 0 = sign-extend, 1 = zero-extend; loads of half/byte only.
- rsp_valid  out  1: response present.
- rsp_ready  in  1: consumer takes the response.
- rsp_rdata  out  32: extended load data; 0 for stores and errors.
- rsp_err  out  2: 00 = ok, 01 = misaligned, 10 = out of range, 11 = illegal size.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/addr/wdata/size/unsigned.
  - Next state is WAIT if WAIT_STATES > 0, else RESP.
- WAIT:
  - Counter loaded with WAIT_STATES-1 at accept; decrements each cycle.
  - Leave for RESP on the cycle the counter equals 0.
- Commit edge: the clock edge entering RESP.
  - Stores write RAM with byte enables.
  - Loads capture the extracted and extended word into rsp_rdata.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - When rsp_ready = 1, go to IDLE.
  - No new request is accepted in the same cycle (req_ready = 0).
- Error priority: illegal size > out of range > misaligned.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Any error suppresses the RAM write and forces rsp_rdata = 0.
- Byte enables:
  - word = 1111
  - half = 0011 << addr[1]*2
  - byte = 0001 << addr[1:0]
  - Write data is replicated across lanes.
- Load extraction:
  - Select the lane by addr offset.
  - Extend from bit 15 (half) or bit 7 (byte) when req_unsigned = 0.
  - Word loads ignore req_unsigned.
- RAM contents are not cleared by reset. Behaviour of never-written locations is undefined (X in simulation).

## Timing
- Reset values (asserted asynchronously): state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 00, wait counter = 0.
- Latency: accept edge to rsp_valid high = 1 + WAIT_STATES cycles.
- Minimum request spacing: 2 + WAIT_STATES cycles when rsp_ready is held high.
- All outputs are registered or decoded from the state register only. There is no combinational path from req_* or rsp_ready to any output.
- Backpressure: rsp_valid stays high and data stays stable for any number of cycles until rsp_ready.
- Reset mid-operation:
  - Reset in IDLE or WAIT discards the transaction; no RAM write occurs.
  - Reset in RESP discards the response; the write has already committed.
- req_valid dropping while req_ready = 0 is legal and ignored. Request fields are sampled only on the accept edge.

## Structure
- Package dmem_pkg holds:
  - size encodings: SZ_WORD, SZ_HALF, SZ_BYTE, SZ_ILL
  - state enum: ST_IDLE, ST_WAIT, ST_RESP
  - error codes: ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_SIZE
- Sub-module dmem_lane_align (purely combinational):
  - Inputs: size, offset, unsigned, wdata, raw read word.
  - Outputs: be[3:0], replicated write data, extended read data, error code.
- The top holds the FSM, wait counter, request latch, RAM array and response registers.

## Test plan
- WAIT_STATES = 0: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 1 cycle after accept, rdata 0xDEADBEEF, err 00.
- Store byte 0x80 @0x13 over 0x00000000, then signed load byte @0x13 -> 0xFFFFFF80; unsigned load byte -> 0x00000080; load word @0x10 -> 0x80000000.
- Load half @0x11 -> err 01, rdata 0. Store word @0x12 -> err 01 and RAM unchanged. Size 11 with addr 0x11 -> err 11 (priority check).
- DEPTH_WORDS = 256: load word @0x400 -> err 10, rdata 0.
- WAIT_STATES = 3: accept at cycle t -> rsp_valid at t+4. Hold rsp_ready = 0 for 5 cycles -> rsp_valid and data stable, req_ready = 0 throughout.
- Assert reset_n low during WAIT of a store 0x12345678 @0x20 (previous contents 0x0) -> outputs take reset values immediately; subsequent load @0x20 returns 0x00000000.
